nmk_111_loader: RTL and testbench

//  Bus-side driver for an NMK-111 latch pair: takes 16-bit words from a host

---
 rtl/nmk_111_loader_if.sv | 27 ++
 rtl/nmk_111_loader.sv | 186 ++++++++++++++++++
 tb/tb_nmk_111_loader.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nmk_111_loader_if.sv
// Host stream and target-bus signals of the NMK-111 loader.
// master: host/bench side; slave: the loader itself.
interface nmk_111_loader_if;
  logic        IN_VALID;
  logic        IN_READY;
  logic [15:0] IN_DATA;
  logic        IN_STAGE2;
  logic        MODE;
  logic        nCS;
  logic        DIR;
  logic [15:0] ABUS_OUT;
  logic        ABUS_OE;
  logic        LCLK1;
  logic        LCLK2;
  logic [15:0] SHADOW_OBUS;
  logic        BUSY;

  modport master (
    output IN_VALID, IN_DATA, IN_STAGE2, MODE,
    input  IN_READY, nCS, DIR, ABUS_OUT, ABUS_OE, LCLK1, LCLK2, SHADOW_OBUS, BUSY
  );

  modport slave (
    input  IN_VALID, IN_DATA, IN_STAGE2, MODE,
    output IN_READY, nCS, DIR, ABUS_OUT, ABUS_OE, LCLK1, LCLK2, SHADOW_OBUS, BUSY
  );
endinterface

// File: rtl/nmk_111_loader.sv
// NMK-111 latch-pair loader: buffers host words in a small FIFO and drives
// them onto the target A-bus with the nCS / LCLK1 / optional LCLK2 sequence,
// keeping a shadow copy of the latch registers.
module nmk_111_loader #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SETUP = 1,
  parameter int unsigned HOLD  = 1
) (
  input  logic               CLK1,
  input  logic               RST,
  nmk_111_loader_if.slave    bus
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned CMAX = (SETUP > HOLD) ? SETUP : HOLD;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CNTW-1:0] FULL       = CNTW'(DEPTH);
  localparam logic [CW-1:0]   SETUP_LAST = CW'(SETUP - 1);
  localparam logic [CW-1:0]   HOLD_LAST  = CW'(HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE1, S_HOLD, S_STROBE2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [16:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q, count_d;
  logic            in_ready_q;
  logic            push, pop;
  logic [16:0]     head;

  logic            ncs_q, ncs_d;
  logic            oe_q, oe_d;
  logic            lclk1_q, lclk1_d;
  logic            lclk2_q, lclk2_d;
  logic            busy_q, busy_d;
  logic            flag_q, flag_d;
  logic [15:0]     abus_q, abus_d;
  logic [15:0]     s1_q, s1_d;
  logic [11:0]     s2_q, s2_d;

  assign push = bus.IN_VALID && in_ready_q;
  assign head = mem_q[rd_ptr_q];

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers, count and registered ready
  always_ff @(posedge CLK1 or posedge RST) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      in_ready_q <= (count_d != FULL);
    end
  end

  // FIFO storage: {stage2 flag, data}
  always_ff @(posedge CLK1) begin
    if (push) mem_q[wr_ptr_q] <= {bus.IN_STAGE2, bus.IN_DATA};
  end

  // State register and phase counter
  always_ff @(posedge CLK1 or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the end of a word (after HOLD or STROBE2) pops the next
  // queued word straight into SETUP so nCS stays low between words
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_SETUP;
          cnt_d   = '0;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) state_d = S_STROBE1;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      S_STROBE1: begin
        state_d = S_HOLD;
        cnt_d   = '0;
      end
      S_HOLD: begin
        if (cnt_q != HOLD_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else if (flag_q) begin
          state_d = S_STROBE2;
        end else if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_SETUP;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STROBE2: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_SETUP;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output next values, decoded from the upcoming state so outputs stay registered
  always_comb begin
    ncs_d   = (state_d == S_IDLE);
    oe_d    = (state_d != S_IDLE);
    lclk1_d = (state_d == S_STROBE1);
    lclk2_d = (state_d == S_STROBE2);
    abus_d  = pop ? head[15:0] : abus_q;
    flag_d  = pop ? head[16]   : flag_q;
    s1_d    = (state_d == S_STROBE1) ? abus_q      : s1_q;
    s2_d    = (state_d == S_STROBE2) ? s1_q[11:0]  : s2_q;
    busy_d  = (state_d != S_IDLE) || (count_d != '0);
  end

  // Output and shadow registers
  always_ff @(posedge CLK1 or posedge RST) begin
    if (RST) begin
      ncs_q   <= 1'b1;
      oe_q    <= 1'b0;
      lclk1_q <= 1'b0;
      lclk2_q <= 1'b0;
      busy_q  <= 1'b0;
      flag_q  <= 1'b0;
      abus_q  <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
    end else begin
      ncs_q   <= ncs_d;
      oe_q    <= oe_d;
      lclk1_q <= lclk1_d;
      lclk2_q <= lclk2_d;
      busy_q  <= busy_d;
      flag_q  <= flag_d;
      abus_q  <= abus_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
    end
  end

  assign bus.IN_READY    = in_ready_q;
  assign bus.nCS         = ncs_q;
  assign bus.DIR         = 1'b0;
  assign bus.ABUS_OUT    = abus_q;
  assign bus.ABUS_OE     = oe_q;
  assign bus.LCLK1       = lclk1_q;
  assign bus.LCLK2       = lclk2_q;
  assign bus.BUSY        = busy_q;
  assign bus.SHADOW_OBUS = bus.MODE ? s1_q : {s1_q[15:12], s2_q};

endmodule

// File: tb/tb_nmk_111_loader.sv
// Scoreboard bench for nmk_111_loader: a default-parameter instance carries
// the randomized traffic, a SETUP=3/HOLD=2 instance checks strobe timing.
module tb_nmk_111_loader;

  localparam int DEPTH_A  = 4;
  localparam int SETUP_A  = 1;
  localparam int HOLD_A   = 1;
  localparam int PERIOD_A = SETUP_A + 1 + HOLD_A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nmk_111_loader_if bif ();
  nmk_111_loader_if bif_b ();

  nmk_111_loader #(.DEPTH(DEPTH_A), .SETUP(SETUP_A), .HOLD(HOLD_A)) dut (
    .CLK1(clk), .RST(rst), .bus(bif)
  );

  nmk_111_loader #(.DEPTH(4), .SETUP(3), .HOLD(2)) dut_b (
    .CLK1(clk), .RST(rst), .bus(bif_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: {stage2, data} in acceptance order, plus the latch model
  logic [16:0] exp_q[$];
  logic [15:0] m_s1 = '0;
  logic [11:0] m_s2 = '0;
  bit          mon_en = 1'b0;

  // Monitor: each LCLK1 pulse consumes one expected word
  initial begin : monitor
    logic [16:0] e;
    bit pend_s2;
    int since;
    logic prev_l1, prev_l2;
    pend_s2 = 0; since = 0; prev_l1 = 0; prev_l2 = 0;
    forever begin
      @(negedge clk);
      if (!mon_en || rst) begin
        pend_s2 = 0; since = 0; prev_l1 = 0; prev_l2 = 0;
      end else begin
        if (pend_s2) since++;
        if (bif.LCLK1) begin
          chk("lclk1_with_lclk2", bif.LCLK2, 1'b0);
          chk("lclk1_after_lclk2", prev_l2, 1'b0);
          chk("lclk2_missing", pend_s2, 1'b0);
          chk("sb_has_word", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("abus_at_lclk1", bif.ABUS_OUT, e[15:0]);
            chk("ncs_at_lclk1", bif.nCS, 1'b0);
            chk("oe_at_lclk1", bif.ABUS_OE, 1'b1);
            m_s1    = e[15:0];
            pend_s2 = e[16];
            since   = 0;
          end
        end
        if (bif.LCLK2) begin
          chk("lclk2_expected", pend_s2, 1'b1);
          chk("lclk2_timing", since, HOLD_A + 1);
          chk("lclk2_after_lclk1", prev_l1, 1'b0);
          m_s2    = m_s1[11:0];
          pend_s2 = 0;
        end
        chk("shadow", bif.SHADOW_OBUS, bif.MODE ? m_s1 : {m_s1[15:12], m_s2});
        chk("dir", bif.DIR, 1'b0);
        prev_l1 = bif.LCLK1;
        prev_l2 = bif.LCLK2;
      end
    end
  end

  // Offer one word; returns with it driven, accepted on the next rising edge
  task automatic send(input logic [15:0] d, input logic s2);
    int w;
    @(posedge clk); #1;
    bif.IN_VALID  = 1'b1;
    bif.IN_DATA   = d;
    bif.IN_STAGE2 = s2;
    w = 0;
    while (!bif.IN_READY && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 200) chk("send_ready_timeout", bif.IN_READY, 1'b1);
    else          exp_q.push_back({s2, d});
  endtask

  task automatic drop();
    @(posedge clk); #1;
    bif.IN_VALID = 1'b0;
  endtask

  task automatic set_mode(input logic m);
    @(posedge clk); #1;
    bif.MODE = m;
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    @(negedge clk);
    while ((bif.BUSY || !bif.nCS) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("drain_busy", bif.BUSY, 1'b0);
  endtask

  int          n_low, first_l1, n_l1, n_l2, n_rise, n_fall, acc, pops, occ, kk, n;
  logic        prev_ncs;
  logic [15:0] sh_at_l2;
  logic [15:0] fill_w[6];
  logic [15:0] rd;
  logic        ncs_h[30], l1_h[30];
  logic [15:0] ab_h[30];
  int          kf, kl, l1cnt, gap;
  logic [15:0] wb1, wb2;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    bif.IN_VALID = 0; bif.IN_DATA = '0; bif.IN_STAGE2 = 0; bif.MODE = 1;
    bif_b.IN_VALID = 0; bif_b.IN_DATA = '0; bif_b.IN_STAGE2 = 0; bif_b.MODE = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ncs", bif.nCS, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", bif.IN_READY, 1'b1);
    chk("rst_ncs_after", bif.nCS, 1'b1);
    chk("rst_oe", bif.ABUS_OE, 1'b0);
    chk("rst_abus", bif.ABUS_OUT, 16'h0000);
    chk("rst_lclk1", bif.LCLK1, 1'b0);
    chk("rst_lclk2", bif.LCLK2, 1'b0);
    chk("rst_busy", bif.BUSY, 1'b0);
    chk("rst_shadow", bif.SHADOW_OBUS, 16'h0000);
    mon_en = 1'b1;

    // Idle: nothing offered for 20 cycles
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("idle_busy", bif.BUSY, 1'b0);
      chk("idle_ncs", bif.nCS, 1'b1);
      chk("idle_lclk", {bif.LCLK1, bif.LCLK2}, 2'b00);
    end

    // Single word, no stage 2
    set_mode(1'b1);
    send(16'hA5C3, 1'b0);
    drop();
    n_low = 0; first_l1 = 0; n_l1 = 0; n_l2 = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (!bif.nCS) n_low++;
      if (bif.LCLK1) begin
        n_l1++;
        if (first_l1 == 0) first_l1 = k;
      end
      if (bif.LCLK2) n_l2++;
    end
    chk("w1_ncs_low_cycles", n_low, 3);
    chk("w1_lclk1_latency", first_l1, 3);
    chk("w1_lclk1_pulses", n_l1, 1);
    chk("w1_lclk2_pulses", n_l2, 0);
    chk("w1_shadow", bif.SHADOW_OBUS, 16'hA5C3);

    // Two back-to-back words, first with stage 2
    set_mode(1'b0);
    send(16'h1234, 1'b1);
    send(16'hF00D, 1'b0);
    drop();
    n_l2 = 0; n_rise = 0; n_fall = 0; prev_ncs = 1'b1; sh_at_l2 = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (prev_ncs && !bif.nCS) n_fall++;
      if (!prev_ncs && bif.nCS) n_rise++;
      prev_ncs = bif.nCS;
      if (bif.LCLK2) begin
        n_l2++;
        sh_at_l2 = bif.SHADOW_OBUS;
      end
    end
    chk("w2_ncs_falls", n_fall, 1);
    chk("w2_ncs_rises", n_rise, 1);
    chk("w2_lclk2_pulses", n_l2, 1);
    chk("w2_shadow_after_word1", sh_at_l2, 16'h1234);
    chk("w2_shadow_after_word2", bif.SHADOW_OBUS, 16'hF234);

    // Fill: 6 words offered back to back; occupancy from the 3-cycle drain rate
    for (int i = 0; i < 6; i++) fill_w[i] = 16'($urandom);
    acc = 0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      kk   = cyc - 1;
      pops = (kk >= 1) ? ((kk - 1) / PERIOD_A + 1) : 0;
      if (pops > acc) pops = acc;
      occ  = acc - pops;
      chk("fill_ready", bif.IN_READY, occ < DEPTH_A);
      if (acc == 6) begin
        bif.IN_VALID = 1'b0;
        break;
      end
      bif.IN_VALID  = 1'b1;
      bif.IN_DATA   = fill_w[acc];
      bif.IN_STAGE2 = 1'b0;
      if (bif.IN_READY) begin
        exp_q.push_back({1'b0, fill_w[acc]});
        acc++;
      end
      @(posedge clk); #1;
    end
    bif.IN_VALID = 1'b0;
    chk("fill_accepted", acc, 6);
    wait_idle(100);
    chk("fill_sb_empty", exp_q.size(), 0);

    // Randomized traffic with gaps and MODE changes
    for (int i = 0; i < 40; i++) begin
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        drop();
        bif.MODE = 1'($urandom_range(0, 1));
        repeat (gap - 1) @(posedge clk);
      end
      rd = 16'($urandom);
      send(rd, 1'($urandom_range(0, 1)));
    end
    drop();
    wait_idle(600);
    chk("rand_sb_empty", exp_q.size(), 0);

    // Reset in the middle of STROBE1 with words still queued
    mon_en = 1'b0;
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b1);
    send(16'h3333, 1'b0);
    drop();
    n = 0;
    @(negedge clk);
    while (!bif.LCLK1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reached_strobe1", bif.LCLK1, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid_lclk1", bif.LCLK1, 1'b0);
    chk("rst_mid_lclk2", bif.LCLK2, 1'b0);
    chk("rst_mid_ncs", bif.nCS, 1'b1);
    chk("rst_mid_oe", bif.ABUS_OE, 1'b0);
    chk("rst_mid_abus", bif.ABUS_OUT, 16'h0000);
    chk("rst_mid_shadow", bif.SHADOW_OBUS, 16'h0000);
    chk("rst_mid_busy", bif.BUSY, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_s1 = '0;
    m_s2 = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("rst_dropped_busy", bif.BUSY, 1'b0);
      chk("rst_dropped_ncs", bif.nCS, 1'b1);
      chk("rst_dropped_lclk1", bif.LCLK1, 1'b0);
    end
    mon_en = 1'b1;

    // SETUP=3 / HOLD=2 instance: strobe spacing and hold of the bus
    wb1 = 16'h5A01;
    wb2 = 16'hC3FE;
    @(negedge clk);
    fork
      begin
        @(posedge clk); #1;
        chk("b_ready0", bif_b.IN_READY, 1'b1);
        bif_b.IN_VALID = 1'b1; bif_b.IN_DATA = wb1; bif_b.IN_STAGE2 = 1'b0;
        @(posedge clk); #1;
        chk("b_ready1", bif_b.IN_READY, 1'b1);
        bif_b.IN_DATA = wb2;
        @(posedge clk); #1;
        bif_b.IN_VALID = 1'b0;
      end
      begin
        for (int k = 0; k < 30; k++) begin
          @(negedge clk);
          ncs_h[k] = bif_b.nCS;
          l1_h[k]  = bif_b.LCLK1;
          ab_h[k]  = bif_b.ABUS_OUT;
        end
      end
    join
    kf = -1; kl = -1; l1cnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (kf < 0 && !ncs_h[k]) kf = k;
      if (kl < 0 && l1_h[k])   kl = k;
      if (l1_h[k]) l1cnt++;
    end
    chk("b_ncs_fall_seen", kf, 2);
    chk("b_setup_gap", kl - kf, 3);
    if (kl < 0 || kl > 26) kl = 0;
    chk("b_abus_at_lclk1", ab_h[kl], wb1);
    chk("b_lclk1_width", l1_h[kl + 1], 1'b0);
    chk("b_abus_hold1", ab_h[kl + 1], wb1);
    chk("b_abus_hold2", ab_h[kl + 2], wb1);
    chk("b_ncs_hold", {ncs_h[kl + 1], ncs_h[kl + 2], ncs_h[kl + 3]}, 3'b000);
    chk("b_abus_next_word", ab_h[kl + 3], wb2);
    chk("b_lclk1_pulses", l1cnt, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
